// File: rtl/l1_i_data_array.sv
// l1_i_data_array: 2-way L1-I line storage with whole-line refill and a registered 32-bit word read.
module l1_i_data_array #(
  parameter int INUM   = 5,
  parameter int L1CBUS = 32,
  parameter int L21BUS = 512
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [INUM-1:0]   index_C_L1,
  input  logic [5:0]        offset,
  input  logic [L21BUS-1:0] read_data_L2_L1,
  input  logic              refill,
  input  logic              way,
  output logic [L1CBUS-1:0] read_data_L1_C
);
  localparam int SETS  = 2**INUM;
  localparam int WORDS = L21BUS / L1CBUS;
  logic [L21BUS-1:0] r_mem [2][SETS];
  logic [WORDS-1:0][L1CBUS-1:0] w_words;
  logic w_unused;
  // Refill data bypasses the array so the new word is returned on the writing edge.
  assign w_words  = refill ? read_data_L2_L1 : r_mem[way][index_C_L1];
  assign w_unused = &{1'b0, offset[1:0]};
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < SETS; s++)
          r_mem[w][s] <= '0;
      read_data_L1_C <= '0;
    end else begin
      if (refill) r_mem[way][index_C_L1] <= read_data_L2_L1;
      read_data_L1_C <= w_words[offset[5:2]];
    end
  end
endmodule

// File: tb/tb_l1_i_data_array.sv
// tb_l1_i_data_array: table vectors plus a reference line model and expected-word queue.
module tb_l1_i_data_array;
  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [4:0]   index_C_L1 = '0;
  logic [5:0]   offset = '0;
  logic [511:0] read_data_L2_L1 = '0;
  logic         refill = 1'b0;
  logic         way = 1'b0;
  logic [31:0]  read_data_L1_C;

  l1_i_data_array dut (
    .clk(clk), .nrst(nrst), .index_C_L1(index_C_L1), .offset(offset),
    .read_data_L2_L1(read_data_L2_L1), .refill(refill), .way(way),
    .read_data_L1_C(read_data_L1_C)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic        w;
    logic [5:0]  off;
    logic [31:0] exp;
  } vec_t;

  logic [511:0] m [2][32];
  logic [31:0]  q [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [511:0] mk_line(input logic [31:0] base, input int i);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base | (32'(i) << 8) | 32'(k);
    return l;
  endfunction

  function automatic logic [31:0] wsel(input logic [511:0] l, input logic [5:0] o);
    return l[int'(o[5:2])*32 +: 32];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive, queue the expectation, let one rising edge pass, compare.
  task automatic step(input logic [4:0] i, input logic w, input logic [5:0] o,
                      input logic rf, input logic [511:0] d, input logic [31:0] exp,
                      input string nm);
    logic [31:0] e;
    index_C_L1 = i; way = w; offset = o; refill = rf; read_data_L2_L1 = d;
    q.push_back(exp);
    if (rf) m[w][i] = d;
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    check(nm, read_data_L1_C, e);
    refill = 1'b0;
  endtask

  task automatic rd(input logic [4:0] i, input logic w, input logic [5:0] o, input string nm);
    step(i, w, o, 1'b0, 512'bx, wsel(m[w][i], o), nm);
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 32; s++) m[w][s] = '0;
  endtask

  vec_t tbl [10];
  logic [511:0] rl;

  initial begin
    tbl[0] = '{5'd5,  1'b0, 6'h00, 32'h0000_0500};
    tbl[1] = '{5'd5,  1'b1, 6'h00, 32'h1000_0500};
    tbl[2] = '{5'd0,  1'b0, 6'h3C, 32'h0000_000F};
    tbl[3] = '{5'd31, 1'b0, 6'h3F, 32'h0000_1F0F};
    tbl[4] = '{5'd31, 1'b1, 6'h04, 32'h1000_1F01};
    tbl[5] = '{5'd17, 1'b0, 6'h21, 32'h0000_1108};
    tbl[6] = '{5'd17, 1'b1, 6'h22, 32'h1000_1108};
    tbl[7] = '{5'd0,  1'b1, 6'h3F, 32'h1000_000F};
    tbl[8] = '{5'd10, 1'b0, 6'h14, 32'h0000_0A05};
    tbl[9] = '{5'd10, 1'b1, 6'h2B, 32'h1000_0A0A};
    clear_model();

    repeat (5) @(negedge clk);
    check("reset_out", read_data_L1_C, 32'h0);
    nrst = 1'b1;
    rd(5'd0, 1'b0, 6'h00, "post_reset_rd0");
    rd(5'd19, 1'b1, 6'h2C, "post_reset_rd1");

    for (int i = 0; i < 32; i++)
      step(5'(i), 1'b0, 6'h08, 1'b1, mk_line(32'h0, i), 32'(i << 8) | 32'd2, "way0_fill");
    for (int i = 0; i < 32; i++)
      step(5'(i), 1'b1, 6'h08, 1'b1, mk_line(32'h1000_0000, i),
           32'h1000_0000 | 32'(i << 8) | 32'd2, "way1_fill");

    for (int t = 0; t < 10; t++)
      step(tbl[t].idx, tbl[t].w, tbl[t].off, 1'b0, 512'bx, tbl[t].exp, "table_vec");

    for (int i = 0; i < 32; i++)
      for (int w = 0; w < 2; w++) begin
        for (int o = 0; o < 64; o += 4) rd(5'(i), w[0], 6'(o), "sweep");
        rd(5'(i), w[0], 6'h3F, "sweep_3f");
      end

    rl = mk_line(32'hA500_0000, 3);
    step(5'd3, 1'b0, 6'h10, 1'b1, rl, 32'hA500_0304, "repl_w0_bypass");
    step(5'd3, 1'b0, 6'h30, 1'b0, 512'bx, 32'hA500_030C, "repl_w0_new");
    step(5'd3, 1'b1, 6'h30, 1'b0, 512'bx, 32'h1000_030C, "repl_w1_kept");
    step(5'd4, 1'b0, 6'h30, 1'b0, 512'bx, 32'h0000_040C, "repl_neighbor");
    rl = mk_line(32'h5A00_0000, 3);
    step(5'd3, 1'b1, 6'h00, 1'b1, rl, 32'h5A00_0300, "repl_w1_bypass");
    step(5'd3, 1'b1, 6'h3C, 1'b0, 512'bx, 32'h5A00_030F, "repl_w1_new");
    step(5'd3, 1'b0, 6'h3C, 1'b0, 512'bx, 32'hA500_030F, "repl_w0_kept");

    step(5'd9, 1'b0, 6'h18, 1'b1, rl, 32'h5A00_0306, "idem_1");
    step(5'd9, 1'b0, 6'h18, 1'b1, rl, 32'h5A00_0306, "idem_2");
    step(5'd9, 1'b0, 6'h18, 1'b0, 512'bx, 32'h5A00_0306, "idem_hold");
    step(5'd9, 1'b0, 6'h18, 1'b0, 512'bx, 32'h5A00_0306, "idem_hold2");

    rd(5'd20, 1'b1, 6'h1C, "pre_async");
    #2 nrst = 1'b0;
    #1 check("async_rst_now", read_data_L1_C, 32'h0);
    clear_model();
    index_C_L1 = 5'd20; way = 1'b1; refill = 1'b1; read_data_L2_L1 = mk_line(32'hFF00_0000, 20);
    @(negedge clk);
    refill = 1'b0;
    check("async_rst_hold", read_data_L1_C, 32'h0);
    nrst = 1'b1;
    rd(5'd20, 1'b1, 6'h1C, "post_async_rd0");
    rd(5'd5, 1'b0, 6'h00, "post_async_rd1");
    rd(5'd31, 1'b1, 6'h3F, "post_async_rd2");
    step(5'd31, 1'b1, 6'h3F, 1'b1, mk_line(32'h7700_0000, 31), 32'h7700_1F0F, "refill_after_rst");

    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/l1_i_data_array.md
Name: l1_i_data_array

Overview:
- Data storage for the 2-way set-associative L1 instruction cache.
- Each set holds one 512-bit line per way. A line is written whole from L2 on refill.
- Each cycle, one 32-bit instruction word is returned to the core, selected by index, way and byte offset.
- The block sits between the L1-I controller/tag array (which supplies way and refill) and the L2 refill bus.

Parameters:
- INUM, 5: number of index bits; number of sets = 2**INUM (default 32).
- L1CBUS, 32: width of the word returned to the core.
- L21BUS, 512: line width and L2-to-L1 refill bus width; must equal 8 × 2**6 (64-byte line).
- Associativity is fixed at 2 (way select is 1 bit).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nrst  in  1  asynchronous active-low reset.
- index_C_L1  in  INUM  set index (address bits [6+:INUM]).
- offset  in  6  byte offset within line (address bits [5:0]).
- read_data_L2_L1  in  L21BUS  refill line from L2.
- refill  in  1  1 = write read_data_L2_L1 into the selected set/way this cycle.
- way  in  1  way select for both read and refill (0 or 1).
- read_data_L1_C  out  L1CBUS  selected instruction word to core.

Behaviour:
- Storage: two banks (way0, way1) of 2**INUM lines × L21BUS bits.
- Reset: while nrst=0 (asynchronous assert, synchronous release on next edge), all line contents are cleared to 0 and read_data_L1_C=0.
- Word select: word = offset[5:2] (0..15). The word occupies line bits [32*word +: 32], so word 0 is line bits [31:0]. offset[1:0] is ignored, since accesses are word aligned.
- Refill write: on a rising edge with nrst=1 and refill=1, line[way][index_C_L1] <= read_data_L2_L1. The write always covers the full line; there are no partial writes.
- Read: on every rising edge with nrst=1, read_data_L1_C <= word offset[5:2] of line[way][index_C_L1]. This gives one-cycle latency from the address/way inputs to the output.
- Read/write collision: when refill=1, the output is taken from the incoming read_data_L2_L1 (write-first bypass), not the old contents. The refilled word is therefore visible on read_data_L1_C after the same edge that writes it.
- Only the addressed set/way changes on a refill; the other way of the same set and all other sets are untouched.
- Inputs held constant for several cycles: the output stays stable, and a repeated refill with the same data is idempotent.
- read_data_L2_L1 may be X while refill=0; it must not affect state or output then.
- No handshake or valid signal: the controller guarantees refill is asserted only when L2 data is valid.
- Reset mid-operation: contents and output are cleared immediately; a refill in progress is lost.

Test Plan:
- Reset: hold nrst=0 for 5 cycles → read_data_L1_C=0. After release, any index/way/offset read returns 0.
- Way0 fill: for index 0..31 with way=0 and refill=1, drive a distinct line D[i] with word k = 32'h(i<<8|k). With offset=6'h08 → output 32'h(i<<8|2) one cycle after the write edge (bypass).
- Way1 fill: repeat for way=1 with different data E[i] → each way0 line is unchanged. Re-reading way0 index 5, offset 0 gives word 0 of D[5].
- Hit reads: refill=0, sweep all indices, both ways and offsets 0x00..0x3C in steps of 4 → each output equals the stored word one cycle later. Offset 0x3F returns the same word as 0x3C.
- Replacement: with refill=1, way=0, index 3, drive new line R → way0 index 3 now returns R's words and way1 index 3 still returns E[3]. Repeat on way1 and confirm way0 is untouched.
- Async reset mid-sequence: assert nrst=0 between clock edges after fills → output goes 0 immediately, and all subsequent reads return 0 until refilled.
